// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, line geometry and address-field helpers for the
// direct-mapped data cache.
//   state_t      - cache controller states
//   LINE_WORDS   - 32-bit words per line
//   LINE_BITS    - bits per line
//   addr_offset  - word offset within a line (addr[3:2])
//   addr_index   - set index, for an index width of idx bits
//   addr_tag     - tag above the index, for an index width of idx bits
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } state_t;

    localparam int LINE_WORDS = 4;
    localparam int WORD_BITS  = 32;
    localparam int LINE_BITS  = LINE_WORDS * WORD_BITS;

    function automatic logic [1:0] addr_offset(input logic [31:0] a);
        return a[3:2];
    endfunction

    // Callers size-cast the result down to the index width.
    function automatic logic [31:0] addr_index(input logic [31:0] a, input int idx);
        return (a >> 4) & ((32'd1 << idx) - 32'd1);
    endfunction

    // Callers size-cast the result down to the tag width.
    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int idx);
        return a >> (4 + idx);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag / valid / dirty / data storage for the data cache.
// One index port serves both the asynchronous read and all writes, because the
// controller only ever touches the set of the request it is working on.
//   clk, reset          - clock, asynchronous active-high reset (clears valid/dirty)
//   index               - set being read / written
//   rd_valid/dirty/tag  - state of the selected set
//   rd_line             - data of the selected set, word 0 in bits [31:0]
//   word_we/off/data    - store one word and mark the line dirty
//   fill_we/tag/line    - replace the whole line: valid=1, dirty=0, new tag
//   clean_we            - clear dirty after a completed write-back
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int IDX      = 4,
    parameter int TAG_W    = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX-1:0]       index,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 word_we,
    input  logic [1:0]           word_off,
    input  logic [31:0]          word_data,
    input  logic                 fill_we,
    input  logic [TAG_W-1:0]     fill_tag,
    input  logic [LINE_BITS-1:0] fill_line,
    input  logic                 clean_we
);

    logic [NUM_SETS-1:0] valid_reg;
    logic [NUM_SETS-1:0] dirty_reg;
    logic [TAG_W-1:0]    tag_mem [NUM_SETS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (fill_we) begin
            valid_reg[index] <= 1'b1;
            dirty_reg[index] <= 1'b0;
        end else if (word_we) begin
            dirty_reg[index] <= 1'b1;
        end else if (clean_we) begin
            dirty_reg[index] <= 1'b0;
        end
    end

    // Tag and data contents are meaningless while valid is clear, so they
    // carry no reset and can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[index] <= fill_tag;
        end
    end

    // One RAM per word lane so a store touches exactly one word.
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
        logic [WORD_BITS-1:0] word_mem [NUM_SETS];

        always_ff @(posedge clk) begin
            if (fill_we) begin
                word_mem[index] <= fill_line[gi*WORD_BITS +: WORD_BITS];
            end else if (word_we && word_off == 2'(gi)) begin
                word_mem[index] <= word_data;
            end
        end

        assign rd_line[gi*WORD_BITS +: WORD_BITS] = word_mem[index];
    end

    assign rd_valid = valid_reg[index];
    assign rd_dirty = dirty_reg[index];
    assign rd_tag   = tag_mem[index];

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// Core side uses a ready/valid handshake; memory side moves 128-bit lines with
// a level-held request and a one-cycle ack.
//   clk, reset                  - clock, asynchronous active-high reset
//   is_input_valid, addr, mem_read, mem_write, din - core request
//   is_ready                    - cache idle and able to accept a request
//   is_output_valid, dout, is_hit - completion pulse, load data, first-compare hit
//   mem_req, mem_we, mem_addr, mem_wdata - line transaction to memory
//   mem_ack, mem_rdata          - transaction done, fill data
//   num_hits, num_misses        - first-compare hit/miss counters
module data_cache
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_input_valid,
    input  logic [31:0]          addr,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          din,
    output logic                 is_ready,
    output logic                 is_output_valid,
    output logic [31:0]          dout,
    output logic                 is_hit,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [LINE_BITS-1:0] mem_rdata,
    output logic [31:0]          num_hits,
    output logic [31:0]          num_misses
);

    localparam int IDX   = $clog2(NUM_SETS);
    localparam int TAG_W = 28 - IDX;

    state_t state_reg, state_next;

    logic [31:0] req_addr_reg;
    logic [31:0] req_din_reg;
    logic        req_store_reg;
    logic        first_reg;        // next compare is the request's first
    logic        out_valid_reg;
    logic        hit_reg;
    logic [31:0] dout_reg;
    logic [31:0] num_hits_reg;
    logic [31:0] num_misses_reg;

    logic [IDX-1:0]       req_index;
    logic [TAG_W-1:0]     req_tag;
    logic [1:0]           req_off;
    logic                 rd_valid, rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_line;
    logic                 tag_hit;
    logic                 word_we, fill_we, clean_we, cmp_done, accept;

    assign req_index = IDX'(addr_index(req_addr_reg, IDX));
    assign req_tag   = TAG_W'(addr_tag(req_addr_reg, IDX));
    assign req_off   = addr_offset(req_addr_reg);
    assign tag_hit   = rd_valid && (rd_tag == req_tag);

    dcache_array #(
        .NUM_SETS (NUM_SETS),
        .IDX      (IDX),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .index     (req_index),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .word_we   (word_we),
        .word_off  (req_off),
        .word_data (req_din_reg),
        .fill_we   (fill_we),
        .fill_tag  (req_tag),
        .fill_line (mem_rdata),
        .clean_we  (clean_we)
    );

    // Memory-port outputs are decoded from state so that an asynchronous
    // reset drops mem_req immediately.
    always_comb begin
        state_next = state_reg;
        is_ready   = 1'b0;
        accept     = 1'b0;
        cmp_done   = 1'b0;
        word_we    = 1'b0;
        fill_we    = 1'b0;
        clean_we   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            ST_IDLE: begin
                is_ready = 1'b1;
                if (is_input_valid) begin
                    accept     = 1'b1;
                    state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (tag_hit) begin
                    cmp_done   = 1'b1;
                    word_we    = req_store_reg;
                    state_next = ST_IDLE;
                end else if (rd_valid && rd_dirty) begin
                    state_next = ST_WRITEBACK;
                end else begin
                    state_next = ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {rd_tag, req_index, 4'b0};
                mem_wdata = rd_line;
                if (mem_ack) begin
                    clean_we   = 1'b1;
                    state_next = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_index, 4'b0};
                if (mem_ack) begin
                    fill_we    = 1'b1;
                    state_next = ST_COMPARE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr_reg   <= '0;
            req_din_reg    <= '0;
            req_store_reg  <= 1'b0;
            first_reg      <= 1'b0;
            out_valid_reg  <= 1'b0;
            hit_reg        <= 1'b0;
            dout_reg       <= '0;
            num_hits_reg   <= '0;
            num_misses_reg <= '0;
        end else begin
            out_valid_reg <= cmp_done;
            hit_reg       <= cmp_done && first_reg;
            if (accept) begin
                req_addr_reg  <= addr;
                req_din_reg   <= din;
                req_store_reg <= mem_write;   // store wins; neither = load
                first_reg     <= 1'b1;
            end
            if (state_reg == ST_COMPARE) begin
                first_reg <= 1'b0;
                if (first_reg) begin
                    if (tag_hit) begin
                        num_hits_reg <= num_hits_reg + 32'd1;
                    end else begin
                        num_misses_reg <= num_misses_reg + 32'd1;
                    end
                end
            end
            if (cmp_done && !req_store_reg) begin
                dout_reg <= rd_line[{req_off, 5'b0} +: WORD_BITS];
            end
        end
    end

    assign is_output_valid = out_valid_reg;
    assign is_hit          = hit_reg;
    assign dout            = dout_reg;
    assign num_hits        = num_hits_reg;
    assign num_misses      = num_misses_reg;

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: randomized self-checking bench for data_cache. A set-level
// reference model (per-set valid/dirty/tag/line plus a sparse backing memory)
// predicts hits, memory transactions, latency, load data and counters.
module tb_data_cache;

    localparam int NUM_SETS = 16;
    localparam int IDX      = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         is_input_valid = 1'b0;
    logic [31:0]  addr = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  din = '0;
    logic         is_ready;
    logic         is_output_valid;
    logic [31:0]  dout;
    logic         is_hit;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic [31:0]  num_hits;
    logic [31:0]  num_misses;

    always #5 clk = ~clk;

    data_cache #(.NUM_SETS(NUM_SETS)) dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .din             (din),
        .is_ready        (is_ready),
        .is_output_valid (is_output_valid),
        .dout            (dout),
        .is_hit          (is_hit),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .num_hits        (num_hits),
        .num_misses      (num_misses)
    );

    int checks   = 0;
    int failures = 0;
    int txn_num  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model
    logic         m_valid [NUM_SETS];
    logic         m_dirty [NUM_SETS];
    logic [31:0]  m_tag   [NUM_SETS];
    logic [127:0] m_line  [NUM_SETS];
    logic [127:0] backing [logic [31:0]];
    int           exp_hits   = 0;
    int           exp_misses = 0;
    logic [31:0]  exp_dout   = '0;

    task automatic model_clear();
        for (int i = 0; i < NUM_SETS; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
        exp_dout   = '0;
    endtask

    task automatic get_line(input logic [31:0] la, output logic [127:0] line);
        if (!backing.exists(la)) begin
            backing[la] = {$urandom, $urandom, $urandom, $urandom};
        end
        line = backing[la];
    endtask

    task automatic do_access(input logic [31:0] a, input logic rd, input logic wr,
                             input logic [31:0] d, input int lat);
        logic [31:0]  idx, tg, wb_addr, fill_addr;
        logic [127:0] wb_data, fill_data, rline;
        int           off, exp_cycles, cycles, cnt, ntx, exp_ntx, wait_cnt;
        logic         exp_hit, exp_wb, done;
        logic [31:0]  tx_addr  [2];
        logic         tx_we    [2];
        logic [127:0] tx_wdata [2];

        // Predict from the cache's rules.
        idx       = (a >> 4) % NUM_SETS;
        tg        = a >> (4 + IDX);
        off       = int'(a[3:2]);
        fill_addr = {a[31:4], 4'b0};
        exp_hit   = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb    = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        if (exp_hit) begin
            exp_hits++;
            exp_cycles = 1;
            exp_ntx    = 0;
        end else begin
            exp_misses++;
            exp_wb = m_valid[idx] && m_dirty[idx];
            if (exp_wb) begin
                wb_addr = (m_tag[idx] << (4 + IDX)) | (idx << 4);
                wb_data = m_line[idx];
                backing[wb_addr] = wb_data;
            end
            get_line(fill_addr, fill_data);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_line[idx]  = fill_data;
            exp_cycles   = exp_wb ? 2 * lat + 2 : lat + 2;
            exp_ntx      = exp_wb ? 2 : 1;
        end
        if (wr) begin
            m_line[idx][off*32 +: 32] = d;
            m_dirty[idx] = 1'b1;
        end else begin
            exp_dout = m_line[idx][off*32 +: 32];
        end

        // Drive the request.
        wait_cnt = 0;
        while (!is_ready && wait_cnt < 10) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("ready_before_req", is_ready, 1'b1);
        is_input_valid = 1'b1;
        addr = a; mem_read = rd; mem_write = wr; din = d;
        @(posedge clk); #1;
        // Garbage on the core inputs must be ignored from here on.
        is_input_valid = 1'b0;
        addr = $urandom; din = $urandom; mem_read = 1'b0; mem_write = 1'b1;

        cycles = 0; cnt = 0; ntx = 0; done = 1'b0;
        while (!done && cycles < 100) begin
            if (is_output_valid) begin
                done = 1'b1;
            end else begin
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                if (mem_req) begin
                    cnt++;
                    if (cnt == 1) begin
                        if (ntx < 2) begin
                            tx_addr[ntx]  = mem_addr;
                            tx_we[ntx]    = mem_we;
                            tx_wdata[ntx] = mem_wdata;
                        end
                        ntx++;
                    end else if (ntx <= 2) begin
                        check("mem_addr_stable", mem_addr, tx_addr[ntx-1]);
                        check("mem_we_stable", mem_we, tx_we[ntx-1]);
                    end
                    if (cnt >= lat) begin
                        mem_ack = 1'b1;
                        if (!mem_we) begin
                            get_line(mem_addr, rline);
                            mem_rdata = rline;
                        end
                        cnt = 0;
                    end
                end
                @(posedge clk); #1;
                mem_ack = 1'b0;
                cycles++;
            end
        end

        check("completed", done, 1'b1);
        if (done) begin
            check("latency", cycles, exp_cycles);
            check("is_hit", is_hit, exp_hit);
            check("dout", dout, exp_dout);
            check("num_hits", num_hits, exp_hits);
            check("num_misses", num_misses, exp_misses);
            check("is_ready_at_done", is_ready, 1'b1);
            check("mem_txn_count", ntx, exp_ntx);
            if (ntx == exp_ntx && exp_wb) begin
                check("wb_we", tx_we[0], 1'b1);
                check("wb_addr", tx_addr[0], wb_addr);
                check("wb_wdata", tx_wdata[0], wb_data);
            end
            if (ntx == exp_ntx && !exp_hit) begin
                check("fill_we", tx_we[ntx-1], 1'b0);
                check("fill_addr", tx_addr[ntx-1], fill_addr);
            end
        end
        $display("txn %0d addr=%h %s hit=%0d wb=%0d lat=%0d cycles=%0d dout=%h",
                 txn_num, a, wr ? "ST" : "LD", exp_hit, exp_wb, lat, cycles, dout);
        txn_num++;
        // The completion pulse lasts exactly one cycle.
        @(posedge clk); #1;
        check("pulse_one_cycle", is_output_valid, 1'b0);
    endtask

    logic [31:0] ra;
    logic        rwr;

    initial begin
        model_clear();

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_is_ready", is_ready, 1'b1);
        check("rst_out_valid", is_output_valid, 1'b0);
        check("rst_is_hit", is_hit, 1'b0);
        check("rst_dout", dout, 32'd0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 128'd0);
        check("rst_num_hits", num_hits, 32'd0);
        check("rst_num_misses", num_misses, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed sequence
        backing[32'h40] = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        do_access(32'h40, 1'b1, 1'b0, 32'h0, 5);
        check("cold_dout_A", dout, 32'hAAAA0001);
        do_access(32'h44, 1'b1, 1'b0, 32'h0, 5);
        check("hit_dout_B", dout, 32'hBBBB0002);
        do_access(32'h48, 1'b0, 1'b1, 32'h12345678, 5);
        do_access(32'h140, 1'b1, 1'b0, 32'h0, 20);
        check("evicted_line", backing[32'h40],
              {32'hDDDD0004, 32'h12345678, 32'hBBBB0002, 32'hAAAA0001});
        do_access(32'h48, 1'b1, 1'b0, 32'h0, 1);
        check("refill_stored_word", dout, 32'h12345678);

        // Spurious ack while idle
        mem_ack = 1'b1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("spur_is_ready", is_ready, 1'b1);
        check("spur_mem_req", mem_req, 1'b0);
        check("spur_out_valid", is_output_valid, 1'b0);
        check("spur_num_hits", num_hits, exp_hits);
        check("spur_num_misses", num_misses, exp_misses);
        do_access(32'h4C, 1'b1, 1'b0, 32'h0, 3);

        // Both read and write set: a store
        do_access(32'h44, 1'b1, 1'b1, 32'hCAFEF00D, 2);
        do_access(32'h44, 1'b1, 1'b0, 32'h0, 2);
        check("both_set_store", dout, 32'hCAFEF00D);

        // Reset in the middle of an allocate
        is_input_valid = 1'b1; addr = 32'h200; mem_read = 1'b1; mem_write = 1'b0;
        @(posedge clk); #1;
        is_input_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_alloc_req", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_is_ready", is_ready, 1'b1);
        check("abort_num_hits", num_hits, 32'd0);
        check("abort_num_misses", num_misses, 32'd0);
        check("abort_dout", dout, 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        do_access(32'h40, 1'b1, 1'b0, 32'h0, 4);
        check("post_reset_miss", num_misses, 32'd1);

        // Randomized traffic over a few tags to force hits and conflicts
        for (int n = 0; n < 300; n++) begin
            ra  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, NUM_SETS - 1) << 4)
                | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            rwr = ($urandom_range(0, 2) == 0);
            do_access(ra, $urandom_range(0, 1) == 1, rwr, $urandom,
                      ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 20));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the single-cycle core's load/store path and a multi-cycle main memory. It replaces the zero-latency data memory port with a request/ready handshake so the core can stall on misses. The memory side moves whole 128-bit lines through a level-held request / one-cycle-ack protocol. Hit and miss counters are exposed for the testbench.

## Interface
Parameters:
- NUM_SETS, 16: number of lines. Power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- is_input_valid  in  1  core presents a request this cycle.
- addr  in  32  byte address. Bits [1:0] are ignored.
- mem_read  in  1  the request is a load.
- mem_write  in  1  the request is a store. Takes precedence if both are set.
- din  in  32  store data.
- is_ready  out  1  the cache can accept a request. High only in IDLE.
- is_output_valid  out  1  one-cycle pulse: the access is complete.
- dout  out  32  load data. Registered; held until the next completion.
- is_hit  out  1  qualifies is_output_valid: the access hit on its first compare.
- mem_req  out  1  memory transaction request, held until ack.
- mem_we  out  1  1 = line write-back, 0 = line fill.
- mem_addr  out  32  line-aligned byte address; bits [3:0] are 0.
- mem_wdata  out  128  victim line; word 0 in bits [31:0].
- mem_ack  in  1  one-cycle pulse: the transaction is done. Fill data is valid in the same cycle.
- mem_rdata  in  128  fill line.
- num_hits  out  32  accesses that hit on their first compare. Wraps modulo 2^32.
- num_misses  out  32  accesses that missed on their first compare. Wraps modulo 2^32.

## Operation
- Address split:
  - word offset = addr[3:2]
  - index = addr[4+IDX-1:4], where IDX = log2(NUM_SETS)
  - tag = addr[31:4+IDX]
- Each line holds valid, dirty, tag and 4×32-bit data.
- State machine states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE:
  - A request is accepted when is_input_valid & is_ready.
  - On acceptance, addr, din and type are latched and the next state is COMPARE.
  - A request with neither mem_read nor mem_write is accepted and completes as a load.
- COMPARE:
  - Hit (valid & tag match): load returns the word to dout. Store writes the word and sets dirty. Pulse is_output_valid and go to IDLE.
  - Miss, victim clean or invalid: go to ALLOCATE.
  - Miss, victim valid and dirty: go to WRITEBACK.
- First-compare bookkeeping:
  - A hit on the first compare of a request increments num_hits and sets is_hit.
  - A miss on the first compare increments num_misses.
  - The re-compare after a fill never changes the counters and reports is_hit=0.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index, 4'b0}, mem_wdata=victim line.
  - On mem_ack: clear dirty and go to ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0, mem_addr={req tag, index, 4'b0}.
  - On mem_ack: write mem_rdata into the line, set valid=1, dirty=0, tag=req tag, then go to COMPARE.
- mem_ack outside WRITEBACK/ALLOCATE is ignored.
- Inputs on the core side are ignored while is_ready=0. The latched request is used throughout.

## Timing
- Reset values:
  - State IDLE, so is_ready=1.
  - is_output_valid=0, is_hit=0, dout=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - num_hits=0, num_misses=0.
  - All valid and dirty bits cleared. Tag and data contents are don't-care.
- Hit latency: accepted at edge T, is_output_valid high in cycle T+1, back in IDLE at T+2.
- Clean miss: COMPARE → ALLOCATE. Done at the ack edge + 2 cycles (re-COMPARE, then the pulse).
- Dirty miss: adds the full write-back transaction before the fill.
- mem_req may stay high from WRITEBACK into ALLOCATE. Memory treats the cycle after an ack as a new request and samples mem_we/mem_addr there.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- Reset asserted mid-miss aborts the transaction:
  - mem_req drops immediately (asynchronous).
  - No write to the array completes, and the cache comes up empty.
- A store hit updates exactly one word. The other three words and the tag are unchanged.

## Structure
- Package dcache_pkg holds:
  - the state enum
  - LINE_WORDS=4 and LINE_BITS=128
  - helper functions for tag/index/offset extraction, parameterised by IDX
- Sub-module dcache_array holds the tag/valid/dirty/data storage:
  - asynchronous read
  - write port with a word-enable for stores and a full-line enable for fills
  - asynchronous clear of valid and dirty on reset
- data_cache holds the FSM, the request latch, the counters and the memory-port drivers.

## Test plan
- Cold load of 0x40 (memory line = {D,C,B,A}, ack after 5 cycles) → one ALLOCATE at mem_addr 0x40. dout=A, is_hit=0, num_misses=1.
- Load 0x44 right after → done at T+1, dout=B, is_hit=1, num_hits=1, no mem_req.
- Store 0x12345678 to 0x48, then load 0x140 (same index 4, tag 1):
  - WRITEBACK at mem_addr 0x40 with mem_wdata={D,0x12345678,B,A}.
  - Then ALLOCATE at 0x140.
- Load 0x40 again after that eviction → clean miss with no write-back. The fill returns the written-back line.
- Reset pulse during ALLOCATE → mem_req=0 immediately, is_ready=1, counters 0. A following load of 0x40 misses.
- Ack latency 1 and 20 cycles; a spurious mem_ack in IDLE → no state change and no counter change. Both mem_read and mem_write set → treated as a store.
